// File: rtl/data_mem_arb_pkg.sv
// rtl/data_mem_arb_pkg.sv - shared constants, FSM encoding and core-slice helpers for data_mem_arbiter
package data_mem_arb_pkg;

    localparam int NUM_CORES  = 4;
    localparam int CORE_IDX_W = 2;

    // Reset value of the round-robin pointer: core 0 is searched first.
    localparam logic [CORE_IDX_W-1:0] LAST_GRANT_RST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2
    } arb_state_t;

    function automatic logic [NUM_CORES-1:0] core_onehot(input logic [CORE_IDX_W-1:0] idx);
        return NUM_CORES'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way round-robin pick; fixed lowest-index priority when ARB_FIXED_PRIO_EN is defined
module rr_arbiter4
    import data_mem_arb_pkg::*;
(
    input  logic [NUM_CORES-1:0]  i_eligible,
    input  logic [CORE_IDX_W-1:0] i_last_grant,
    output logic                  o_grant_valid,
    output logic [CORE_IDX_W-1:0] o_grant_idx
);

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = CORE_IDX_W'(i);
            end
        end
    end
`else
    logic [CORE_IDX_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest eligible core after last_grant wins.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_cand        = '0;
        for (int i = NUM_CORES; i >= 1; i--) begin
            w_cand = i_last_grant + CORE_IDX_W'(i);
            if (i_eligible[w_cand]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_cand;
            end
        end
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - serialises four cores' load/store requests onto one memory port (ARB_FIXED_PRIO_EN selects fixed priority)
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CORES-1:0]              core_req,
    input  logic [NUM_CORES-1:0]              core_we,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]   core_addr,
    input  logic [NUM_CORES*2*DATA_WIDTH-1:0] core_wdata,
    output logic [NUM_CORES-1:0]              core_ack,
    output logic [NUM_CORES*DATA_WIDTH-1:0]   core_rdata,
    output logic                              busy,
    output logic [3:0]                        mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_w_addr,
    output logic [ADDR_WIDTH-1:0]             mem_r_addr,
    output logic [2*DATA_WIDTH-1:0]           mem_w_data,
    input  logic [DATA_WIDTH-1:0]             mem_r_data
);

    arb_state_t                      r_state;
    logic [CORE_IDX_W-1:0]           r_last_grant;
    logic [CORE_IDX_W-1:0]           r_winner;
    logic                            r_we;
    logic [NUM_CORES-1:0]            r_core_ack;
    logic [NUM_CORES*DATA_WIDTH-1:0] r_core_rdata;
    logic                            r_busy;
    logic                            r_mem_we;
    logic [ADDR_WIDTH-1:0]           r_mem_addr;
    logic [2*DATA_WIDTH-1:0]         r_mem_w_data;

    logic [NUM_CORES-1:0]            w_eligible;
    logic                            w_grant_valid;
    logic [CORE_IDX_W-1:0]           w_grant_idx;

    // A core whose ack is on the wire this cycle still shows req high; keep it out of the race.
    assign w_eligible = core_req & ~r_core_ack;

    rr_arbiter4 u_rr_arbiter4 (
        .i_eligible    (w_eligible),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= LAST_GRANT_RST;
            r_winner     <= '0;
            r_we         <= 1'b0;
            r_core_ack   <= '0;
            r_core_rdata <= '0;
            r_busy       <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_w_data <= '0;
        end else begin
            r_core_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_winner     <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_we         <= core_we[w_grant_idx];
                        r_mem_we     <= core_we[w_grant_idx];
                        r_mem_addr   <= core_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        r_mem_w_data <= core_wdata[w_grant_idx*2*DATA_WIDTH +: 2*DATA_WIDTH];
                        r_busy       <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_mem_we <= 1'b0;
                    r_state  <= ST_CAPT;
                end
                ST_CAPT: begin
                    if (!r_we) begin
                        r_core_rdata[r_winner*DATA_WIDTH +: DATA_WIDTH] <= mem_r_data;
                    end
                    r_core_ack <= core_onehot(r_winner);
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_ack   = r_core_ack;
    assign core_rdata = r_core_rdata;
    assign busy       = r_busy;
    assign mem_we     = {3'b000, r_mem_we};
    assign mem_w_addr = r_mem_addr;
    assign mem_r_addr = r_mem_addr;
    assign mem_w_data = r_mem_w_data;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter with a behavioural byte memory
module tb_data_mem_arbiter;

    localparam int DW = 8;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      core_req;
    logic [3:0]      core_we;
    logic [4*AW-1:0] core_addr;
    logic [8*DW-1:0] core_wdata;
    logic [3:0]      core_ack;
    logic [4*DW-1:0] core_rdata;
    logic            busy;
    logic [3:0]      mem_we;
    logic [AW-1:0]   mem_w_addr;
    logic [AW-1:0]   mem_r_addr;
    logic [2*DW-1:0] mem_w_data;
    logic [DW-1:0]   mem_r_data;

    logic [7:0]      tb_mem [0:255];
    logic [7:0]      w_addr_hi;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .busy       (busy),
        .mem_we     (mem_we),
        .mem_w_addr (mem_w_addr),
        .mem_r_addr (mem_r_addr),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    // High byte of a store wraps within the 8-bit address space.
    assign w_addr_hi = mem_w_addr + 8'd1;

    always @(posedge clk) begin
        if (mem_we[0]) begin
            tb_mem[mem_w_addr] <= mem_w_data[7:0];
            tb_mem[w_addr_hi]  <= mem_w_data[15:8];
        end
        mem_r_data <= tb_mem[mem_r_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        core_req   = '0;
        core_we    = '0;
        core_addr  = '0;
        core_wdata = '0;
        rst_n      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_access(input int c, input logic we, input logic [7:0] addr,
                              input logic [15:0] wd, input logic [7:0] exp_rd);
        core_we[c]             = we;
        core_addr[c*AW +: AW]  = addr;
        core_wdata[c*16 +: 16] = wd;
        core_req[c]            = 1'b1;
        check("pre_we", mem_we, 0);
        tick();
        check("issue_busy", busy, 1);
        check("issue_r_addr", mem_r_addr, addr);
        check("issue_w_addr", mem_w_addr, addr);
        check("issue_we", mem_we, {3'b000, we});
        if (we) check("issue_w_data", mem_w_data, wd);
        tick();
        check("capt_busy", busy, 1);
        check("capt_we", mem_we, 0);
        check("capt_ack", core_ack, 0);
        tick();
        check("ack", core_ack, 4'b0001 << c);
        check("ack_busy", busy, 0);
        if (!we) check("rdata", core_rdata[c*DW +: DW], exp_rd);
        core_req[c] = 1'b0;
        tick();
        check("ack_clear", core_ack, 0);
    endtask

    // Hold the cores in req_mask requesting loads; order packs the expected grant sequence LSB-first, 2 bits each.
    task automatic run_pattern(input string tag, input logic [3:0] req_mask, input int n_grants,
                               input logic [15:0] order);
        logic [3:0] exp_ack;
        logic [3:0] served;
        served = '0;
        for (int i = 0; i < 4; i++) begin
            core_addr[i*AW +: AW] = 8'h20 + 8'(i);
            core_we[i]            = 1'b0;
        end
        core_req = req_mask;
        for (int t = 1; t <= 3 * n_grants; t++) begin
            tick();
            exp_ack = '0;
            if (t % 3 == 0) begin
                exp_ack = 4'b0001 << order[2*(t/3-1) +: 2];
                served  = served | exp_ack;
            end
            check(tag, core_ack, exp_ack);
        end
        core_req = '0;
        for (int i = 0; i < 4; i++) begin
            if (served[i]) check({tag, "_rdata"}, core_rdata[i*DW +: DW], 8'hA0 + 8'(i));
        end
        tick();
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] <= 8'h00;
        #1;
        tb_mem[8'h00] <= 8'h05;
        for (int i = 0; i < 4; i++) tb_mem[8'h20 + i] <= 8'hA0 + 8'(i);
        do_reset();

        check("rst_ack", core_ack, 0);
        check("rst_rdata", core_rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_we", mem_we, 0);
        check("rst_w_addr", mem_w_addr, 0);
        check("rst_r_addr", mem_r_addr, 0);
        check("rst_w_data", mem_w_data, 0);

        run_access(0, 1'b0, 8'h00, 16'h0000, 8'h05);

        run_access(2, 1'b1, 8'h10, 16'hBEEF, 8'h00);
        check("st_lo", tb_mem[8'h10], 8'hEF);
        check("st_hi", tb_mem[8'h11], 8'hBE);
        run_access(2, 1'b0, 8'h10, 16'h0000, 8'hEF);
        run_access(2, 1'b0, 8'h11, 16'h0000, 8'hBE);

        run_access(3, 1'b1, 8'hFF, 16'h1234, 8'h00);
        check("wrap_lo", tb_mem[8'hFF], 8'h34);
        check("wrap_hi", tb_mem[8'h00], 8'h12);

        do_reset();
        run_pattern("rr_all4", 4'b1111, 6, {2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0});

        do_reset();
        run_pattern("core0_3", 4'b1001, 4, {2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0});

        do_reset();
`ifdef ARB_FIXED_PRIO_EN
        run_pattern("core012", 4'b0111, 6, {2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0});
`else
        run_pattern("core012", 4'b0111, 6, {2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0});
`endif

        do_reset();
        tb_mem[8'h40] <= 8'h00;
        tb_mem[8'h41] <= 8'h00;
        core_we[1]            = 1'b1;
        core_addr[1*AW +: AW] = 8'h40;
        core_wdata[16 +: 16]  = 16'h5566;
        core_req[1]           = 1'b1;
        tick();
        check("mid_issue_we", mem_we, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_w_addr", mem_w_addr, 0);
        check("mid_rst_w_data", mem_w_data, 0);
        check("mid_rst_ack", core_ack, 0);
        core_req = '0;
        core_we  = '0;
        #1;
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            check("post_rst_no_ack", core_ack, 0);
        end
        check("post_rst_mem", tb_mem[8'h40], 8'h00);
        run_pattern("post_rst", 4'b0011, 2, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
